// File: rtl/display_scan_decoder.sv
// display_scan_decoder: decodes a multiplexed 7-segment scan bus back into 4-digit frames
// CLK/Reset: clock, sync active-high reset; displayCA/displayAN: active-low cathodes/anodes
// Digits: last frame; FrameValid: update pulse; FrameErr: invalid digit in frame
// AnErr: illegal anode dwell pulse; Stalled: no capture for TIMEOUT_CYCLES
module display_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [6:0]  displayCA,
  input  logic [3:0]  displayAN,
  output logic [15:0] Digits,
  output logic        FrameValid,
  output logic        FrameErr,
  output logic        AnErr,
  output logic        Stalled
);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [10:0] smp, prev;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [15:0] shadow, shadow_n;
  logic [3:0] seen, seen_n, an, nib;
  logic [6:0] ca;
  logic [1:0] idx;
  logic done, ferr, bad, hit, one_hot, cap;
  assign an = smp[10:7];
  assign ca = smp[6:0];
  always_comb begin
    case (ca)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b1111111: nib = 4'hF;
      default:    nib = 4'hE;
    endcase
  end
  assign bad     = nib == 4'hE;
  assign one_hot = an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  assign idx     = !an[0] ? 2'd0 : !an[1] ? 2'd1 : !an[2] ? 2'd2 : 2'd3;
  // scnt saturates one past the action point, so the action fires on the edge it gets there
  assign hit     = smp == prev && !done && scnt == SW'(STABLE_CYCLES - 2);
  assign cap     = hit && one_hot;
  assign seen_n  = seen | (4'b1 << idx);
  always_comb begin
    shadow_n = shadow;
    shadow_n[idx*4 +: 4] = nib;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      smp        <= '1;
      prev       <= '1;
      scnt       <= '0;
      done       <= 1'b0;
      tcnt       <= '0;
      shadow     <= '0;
      seen       <= '0;
      ferr       <= 1'b0;
      Digits     <= '0;
      FrameValid <= 1'b0;
      FrameErr   <= 1'b0;
      AnErr      <= 1'b0;
      Stalled    <= 1'b0;
    end else begin
      smp        <= {displayAN, displayCA};
      prev       <= smp;
      FrameValid <= 1'b0;
      AnErr      <= hit && !one_hot && an != 4'hF;
      if (smp != prev) begin
        scnt <= '0;
        done <= 1'b0;
      end else begin
        if (scnt != SW'(STABLE_CYCLES - 1)) scnt <= scnt + 1'b1;
        if (hit) done <= 1'b1;
      end
      if (cap) begin
        shadow  <= shadow_n;
        tcnt    <= '0;
        Stalled <= 1'b0;
        if (seen_n == 4'hF) begin
          Digits     <= shadow_n;
          FrameErr   <= ferr | bad;
          FrameValid <= 1'b1;
          seen       <= '0;
          ferr       <= 1'b0;
        end else begin
          seen <= seen_n;
          ferr <= ferr | bad;
        end
      end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          Stalled <= 1'b1;
          seen    <= '0;
          ferr    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_display_scan_decoder.sv
// tb_display_scan_decoder: directed and random scan stimulus checked against a dwell-level model
module tb_display_scan_decoder;
  localparam int S = 4;
  localparam int T = 64;
  logic CLK = 0, Reset = 1;
  logic [6:0] displayCA = '1;
  logic [3:0] displayAN = '1;
  logic [15:0] Digits;
  logic FrameValid, FrameErr, AnErr, Stalled;
  display_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .Reset(Reset), .displayCA(displayCA), .displayAN(displayAN),
    .Digits(Digits), .FrameValid(FrameValid), .FrameErr(FrameErr),
    .AnErr(AnErr), .Stalled(Stalled)
  );
  always #5 CLK = ~CLK;
  logic [6:0] seg [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  int tests = 0, fails = 0, fv_cnt = 0, ae_cnt = 0;
  logic [10:0] m_last;
  int m_run, m_t;
  logic [3:0] m_sh [4];
  logic [3:0] m_seen;
  logic [15:0] m_digits;
  logic m_ferr, m_fe, m_fv, m_ae, m_st;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [3:0] dec(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (c == seg[i]) return 4'(i);
    return c == 7'h7F ? 4'hF : 4'hE;
  endfunction
  task automatic step();
    logic [10:0] v, av;
    logic act;
    int id;
    v = {displayAN, displayCA};
    m_fv = 0;
    m_ae = 0;
    if (Reset) begin
      m_last = '1; m_run = 0; m_t = 0; m_seen = 0; m_ferr = 0;
      m_digits = 0; m_fe = 0; m_st = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 0;
      return;
    end
    act = m_run == S;
    av = m_last;
    if (v == m_last) m_run++;
    else begin m_last = v; m_run = 1; end
    id = -1;
    if (act) begin
      if ($countones(~av[10:7]) == 1) begin
        for (int i = 0; i < 4; i++) if (!av[7+i]) id = i;
      end else if (av[10:7] != 4'hF) m_ae = 1;
    end
    if (id >= 0) begin
      m_sh[id] = dec(av[6:0]);
      m_seen[id] = 1;
      if (m_sh[id] == 4'hE) m_ferr = 1;
      m_t = 0;
      m_st = 0;
      if (&m_seen) begin
        for (int i = 0; i < 4; i++) m_digits[4*i +: 4] = m_sh[i];
        m_fe = m_ferr; m_fv = 1; m_seen = 0; m_ferr = 0;
      end
    end else if (m_t < T) begin
      m_t++;
      if (m_t == T) begin m_st = 1; m_seen = 0; m_ferr = 0; end
    end
  endtask
  task automatic drive(input logic [3:0] an, input logic [6:0] ca, input int n);
    for (int k = 0; k < n; k++) begin
      displayAN = an;
      displayCA = ca;
      @(posedge CLK);
      step();
      #1;
      chk("FrameValid", FrameValid, m_fv);
      chk("AnErr", AnErr, m_ae);
      chk("Stalled", Stalled, m_st);
      chk("Digits", Digits, m_digits);
      chk("FrameErr", FrameErr, m_fe);
      if (FrameValid) fv_cnt++;
      if (AnErr) ae_cnt++;
    end
  endtask
  task automatic scan(input logic [6:0] c0, c1, c2, c3, input int n);
    drive(4'b1110, c0, n);
    drive(4'b1101, c1, n);
    drive(4'b1011, c2, n);
    drive(4'b0111, c3, n);
  endtask
  initial begin
    int f0;
    Reset = 1;
    for (int k = 0; k < 2; k++) drive(4'($urandom), 7'($urandom), 1);
    chk("rst_digits", Digits, 0);
    chk("rst_fv", FrameValid, 0);
    chk("rst_stalled", Stalled, 0);
    Reset = 0;
    drive(4'hF, 7'h7F, 4);
    chk("rst_nofv", 16'(fv_cnt), 0);
    f0 = fv_cnt;
    scan(seg[1], seg[3], seg[0], seg[0], 8);
    chk("clean_fv", 16'(fv_cnt - f0), 1);
    chk("clean_digits", Digits, 16'h0031);
    chk("clean_ferr", FrameErr, 0);
    chk("clean_stalled", Stalled, 0);
    drive(4'b1110, seg[1], 8);
    drive(4'b1110, seg[2], 3);
    drive(4'b1101, seg[3], 8);
    drive(4'b1011, seg[0], 8);
    drive(4'b0111, seg[0], 8);
    chk("glitch_digits", Digits, 16'h0031);
    drive(4'b1110, seg[2], 4);
    drive(4'b1101, seg[3], 8);
    drive(4'b1011, seg[0], 8);
    drive(4'b0111, seg[0], 8);
    chk("hold4_digits", Digits, 16'h0032);
    scan(seg[1], seg[3], 7'b1111110, 7'b1111111, 8);
    chk("inv_digits", Digits, 16'hFE31);
    chk("inv_ferr", FrameErr, 1);
    f0 = fv_cnt;
    ae_cnt = 0;
    drive(4'b1100, seg[0], 20);
    chk("anerr_cnt", 16'(ae_cnt), 1);
    chk("anerr_seen", 16'(dut.seen), 0);
    chk("anerr_nofv", 16'(fv_cnt - f0), 0);
    drive(4'b1110, seg[5], 8);
    drive(4'b1101, seg[6], 8);
    drive(4'hF, 7'h7F, 60);
    chk("stall_early", Stalled, 0);
    drive(4'hF, 7'h7F, 1);
    chk("stall_64", Stalled, 1);
    drive(4'hF, 7'h7F, 9);
    f0 = fv_cnt;
    drive(4'b1011, seg[7], 8);
    chk("stall_clear", Stalled, 0);
    drive(4'b0111, seg[8], 8);
    chk("stall_nofv", 16'(fv_cnt - f0), 0);
    drive(4'b1110, seg[9], 8);
    drive(4'b1101, seg[4], 8);
    chk("resume_fv", 16'(fv_cnt - f0), 1);
    chk("resume_digits", Digits, 16'h8749);
    drive(4'b1110, seg[1], 8);
    drive(4'b1101, seg[2], 8);
    drive(4'b1011, seg[3], 8);
    Reset = 1;
    drive(4'b1011, seg[3], 2);
    Reset = 0;
    f0 = fv_cnt;
    drive(4'b0111, seg[4], 8);
    chk("rstmid_nofv", 16'(fv_cnt - f0), 0);
    chk("rstmid_digits", Digits, 0);
    for (int d = 0; d < 300; d++) begin
      logic [3:0] an;
      logic [6:0] ca;
      int r;
      r = $urandom_range(0, 99);
      an = r < 70 ? ~(4'b1 << $urandom_range(0, 3)) : r < 85 ? 4'hF : 4'($urandom);
      r = $urandom_range(0, 99);
      ca = r < 80 ? seg[$urandom_range(0, 9)] : r < 90 ? 7'h7F : 7'($urandom);
      drive(an, ca, $urandom_range(1, 10));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/display_scan_decoder.md
# display_scan_decoder

Receive-side counterpart of the temperature controller's multiplexed 7-segment driver. It samples the time-multiplexed `displayCA`/`displayAN` bus and waits for each digit dwell to settle. It decodes each settled dwell back into a 4-bit digit code and publishes a complete 4-digit frame, flagging malformed segments, illegal anode patterns and stalled scanning. It sits on the display bus, for board-level self-check and for the team's regression benches.

## Interface

Parameters:
- `STABLE_CYCLES`, default 16: consecutive identical samples needed before a dwell is captured; minimum 2.
- `TIMEOUT_CYCLES`, default 65536: cycles without any capture before `Stalled` asserts.

Ports (one clock; reset is synchronous and active-high):
- `CLK`, input, 1: system clock; all logic on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `displayCA`, input, 7: cathodes, active-low, bit6..bit0 = segments a,b,c,d,e,f,g.
- `displayAN`, input, 4: anodes, active-low; `displayAN[i]` low selects digit i.
- `Digits`, output, 16: last complete frame; digit i at `[4i+3:4i]`.
- `FrameValid`, output, 1: one-cycle pulse when `Digits` updates.
- `FrameErr`, output, 1: valid with `FrameValid`; 1 if any digit in the frame decoded as invalid.
- `AnErr`, output, 1: one-cycle pulse per stable dwell with more than one anode low.
- `Stalled`, output, 1: level; scan timeout.

## Operation

- **Input sampling:** `{displayAN,displayCA}` is registered once into `smp`. `prev` holds the previous `smp`.
- **Stability counter `scnt`:**
  - Reset to 0 whenever `smp != prev`.
  - Otherwise increments, saturating at `STABLE_CYCLES-1`.
  - A `done` flag allows one action per dwell and clears on any change.
- **Dwell action:** taken when `scnt` reaches `STABLE_CYCLES-1` with `done==0`.
  - Anode pattern exactly one low bit (1110/1101/1011/0111): capture.
  - 1111: ignore (blanking interval).
  - Any other pattern: pulse `AnErr`, no capture.
- **Segment decode (active-low a..g):**
  - 0000001 -> 0
  - 1001111 -> 1
  - 0010010 -> 2
  - 0000110 -> 3
  - 1001100 -> 4
  - 0100100 -> 5
  - 0100000 -> 6
  - 0001111 -> 7
  - 0000000 -> 8
  - 0000100 -> 9
  - 1111111 -> F (blank, legal)
  - Anything else -> E, and sets the frame error accumulator `ferr`.
- **Capture:** writes the decoded nibble into shadow digit i and sets `seen[i]`. A repeat capture of the same digit before frame completion overwrites it.
- **Frame completion:** when a capture makes `seen==1111`:
  - `Digits` <= shadow (including the new nibble).
  - `FrameErr` <= `ferr` (including the new digit).
  - `FrameValid` pulses.
  - `seen` and `ferr` clear.
- **Timeout:** `tcnt` counts cycles since the last capture and resets on every capture. At `TIMEOUT_CYCLES`:
  - `Stalled` <= 1; `seen` and `ferr` clear.
  - `tcnt` holds.
  - The next capture clears `Stalled` on the same edge.
- **Simultaneous events:** a capture and a timeout on the same edge resolve as capture wins.
- **Reset (any time, including mid-frame):**
  - `Digits`=0, `FrameValid`=0, `FrameErr`=0, `AnErr`=0, `Stalled`=0.
  - `seen`=0, `ferr`=0, `scnt`=0, `tcnt`=0, `done`=0.
  - `smp` and `prev` = all-ones (blank).

## Timing

- **Capture edge:** for an input value first present before edge E0, the capture happens at edge E0+`STABLE_CYCLES`. This is one sample stage plus `STABLE_CYCLES-1` matching comparisons.
- **Glitch rejection:** a dwell shorter than `STABLE_CYCLES` cycles is never captured.
- **Frame outputs:** `FrameValid`, `FrameErr` and `Digits` are registered at the completing capture edge, visible in the following cycle. `FrameValid` is exactly one cycle wide.
- **`AnErr` timing:** asserted on the same relative edge as a capture would be, one cycle wide, at most once per dwell.
- **Throughput:** one capture per dwell. Back-to-back frames are supported with no dead cycles beyond the dwells themselves.

## Test plan

Bench parameters: `STABLE_CYCLES`=4, `TIMEOUT_CYCLES`=64.

1. **Reset:** assert `Reset` for 2 cycles with random bus activity -> all outputs 0; no `FrameValid` for 4 cycles after release with the bus at 1111/1111111.
2. **Clean frame:** scan 8 cycles per digit with AN 1110/CA 1001111, AN 1101/CA 0000110, AN 1011/CA 0000001, AN 0111/CA 0000001 -> exactly one `FrameValid`; `Digits`=16'h0031, `FrameErr`=0, `Stalled`=0.
3. **Glitch:** insert AN 1110/CA 0010010 for only 3 cycles between dwells of a "0031" scan -> frame still 16'h0031. Then hold the same value 4 cycles in the next scan -> `Digits`=16'h0032.
4. **Invalid segment / blank:** digit 2 drives CA 1111110, digit 3 drives 1111111 -> `Digits`=16'hFE31, `FrameErr`=1 with `FrameValid`.
5. **Illegal anode:** hold AN 1100/CA 0000001 for 20 cycles -> exactly one `AnErr` pulse; `seen` unchanged; no `FrameValid`.
6. **Stall and reset mid-frame:**
   - Capture digits 0 and 1, then hold AN 1111 for 70 cycles -> `Stalled`=1 at cycle 64 after the last capture.
   - Resume with digit 2 -> `Stalled`=0; no frame until all four digits are seen afresh.
   - Assert `Reset` after 3 captures -> a subsequent single-digit dwell must not complete a frame.
